// File: rtl/spi_pixel_packer_if.sv
// spi_pixel_packer_if
//   Groups the byte-side inputs and pixel-side outputs of spi_pixel_packer.
//   Handshake: there is no back-pressure. byte_vld, frame_start, pix_vld and
//   frame_done are single-cycle strobes qualified only by themselves. Data that
//   accompanies a strobe is valid in the cycle the strobe is high. The producer
//   never waits, so the packer must accept or drop every byte on the cycle it
//   arrives.
//   master : drives byte_vld/byte_dat/stream_en/frame_start, observes outputs
//   slave  : the packer itself
interface spi_pixel_packer_if;
    logic        byte_vld;
    logic [7:0]  byte_dat;
    logic        stream_en;
    logic        frame_start;
    logic        pix_vld;
    logic [15:0] pix_dat1;
    logic [15:0] pix_dat2;
    logic [10:0] pixX;
    logic [10:0] pixY;
    logic        frame_done;
    logic        busy;
    logic        ovf;

    modport master (
        output byte_vld, byte_dat, stream_en, frame_start,
        input  pix_vld, pix_dat1, pix_dat2, pixX, pixY, frame_done, busy, ovf
    );

    modport slave (
        input  byte_vld, byte_dat, stream_en, frame_start,
        output pix_vld, pix_dat1, pix_dat2, pixX, pixY, frame_done, busy, ovf
    );
endinterface

// File: rtl/spi_pixel_packer.sv
// spi_pixel_packer
//   Packs groups of six SPI bytes into a stereo RGB565 pixel pair with X/Y
//   coordinates, a frame-end strobe and sticky overrun detection.
//   Ports:
//     clk_p     : system clock, rising edge
//     rst_p     : synchronous active-low reset
//     bus       : spi_pixel_packer_if.slave (byte input, pixel output)
//     dbg_state : current FSM state (0 IDLE, 1 RUN, 2 DONE)
module spi_pixel_packer #(
    parameter int ImageW = 640,
    parameter int ImageH = 480
) (
    input  logic                 clk_p,
    input  logic                 rst_p,
    spi_pixel_packer_if.slave    bus,
    output logic [1:0]           dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    localparam logic [10:0] XMax = 11'(ImageW - 1);
    localparam logic [10:0] YMax = 11'(ImageH - 1);

    state_e      state_q, state_d;
    logic [2:0]  bc_q, bc_d;
    // Only bytes b0..b4 need storage; b5 is taken straight from byte_dat.
    logic [7:0]  slot_q [5];
    logic [7:0]  slot_d [5];
    logic [10:0] x_q, x_d;          // position of the next pixel to emit
    logic [10:0] y_q, y_d;
    logic        pix_vld_q, pix_vld_d;
    logic [15:0] pix_dat1_q, pix_dat1_d;
    logic [15:0] pix_dat2_q, pix_dat2_d;
    logic [10:0] pix_x_q, pix_x_d;  // position of the pixel on the outputs
    logic [10:0] pix_y_q, pix_y_d;
    logic        frame_done_q, frame_done_d;
    logic        ovf_q, ovf_d;

    always_comb begin
        state_d      = state_q;
        bc_d         = bc_q;
        slot_d       = slot_q;
        x_d          = x_q;
        y_d          = y_q;
        pix_vld_d    = 1'b0;
        pix_dat1_d   = pix_dat1_q;
        pix_dat2_d   = pix_dat2_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        frame_done_d = 1'b0;
        ovf_d        = ovf_q;

        if (bus.frame_start) begin
            // Arming a frame overrides any same-cycle byte.
            state_d = RUN;
            bc_d    = 3'd0;
            x_d     = 11'd0;
            y_d     = 11'd0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (!bus.stream_en) begin
                        bc_d = 3'd0;
                    end else if (bus.byte_vld) begin
                        if (bc_q == 3'd5) begin
                            bc_d       = 3'd0;
                            pix_vld_d  = 1'b1;
                            pix_dat2_d = {slot_q[0][7:3], slot_q[1][7:2], slot_q[2][7:3]};
                            pix_dat1_d = {slot_q[3][7:3], slot_q[4][7:2], bus.byte_dat[7:3]};
                            pix_x_d    = x_q;
                            pix_y_d    = y_q;
                            if (x_q == XMax) begin
                                x_d = 11'd0;
                                if (y_q == YMax) begin
                                    frame_done_d = 1'b1;
                                    state_d      = DONE;
                                end else begin
                                    y_d = y_q + 11'd1;
                                end
                            end else begin
                                x_d = x_q + 11'd1;
                            end
                        end else begin
                            for (int i = 0; i < 5; i++) begin
                                if (bc_q == 3'(i)) slot_d[i] = bus.byte_dat;
                            end
                            bc_d = bc_q + 3'd1;
                        end
                    end
                end
                DONE: begin
                    if (bus.byte_vld) ovf_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_p) begin
        if (!rst_p) begin
            state_q      <= IDLE;
            bc_q         <= 3'd0;
            for (int i = 0; i < 5; i++) slot_q[i] <= 8'd0;
            x_q          <= 11'd0;
            y_q          <= 11'd0;
            pix_vld_q    <= 1'b0;
            pix_dat1_q   <= 16'd0;
            pix_dat2_q   <= 16'd0;
            pix_x_q      <= 11'd0;
            pix_y_q      <= 11'd0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bc_q         <= bc_d;
            slot_q       <= slot_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pix_vld_q    <= pix_vld_d;
            pix_dat1_q   <= pix_dat1_d;
            pix_dat2_q   <= pix_dat2_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.pix_vld    = pix_vld_q;
    assign bus.pix_dat1   = pix_dat1_q;
    assign bus.pix_dat2   = pix_dat2_q;
    assign bus.pixX       = pix_x_q;
    assign bus.pixY       = pix_y_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state_q == RUN);
    assign bus.ovf        = ovf_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_spi_pixel_packer.sv
// tb_spi_pixel_packer
//   Bench for spi_pixel_packer with a small 4x2 frame. A behavioural model
//   collects accepted bytes in a queue, counts pixels per frame and derives
//   coordinates as count % W, count / W.
module tb_spi_pixel_packer;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int PW = 54;   // {dat1, dat2, x, y}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    spi_pixel_packer_if bus ();

    spi_pixel_packer #(.ImageW(W), .ImageH(H)) dut (
        .clk_p     (clk),
        .rst_p     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [PW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]    grp[$];
    int            pix_count = 0;
    bit            running = 0;
    bit            frame_over = 0;
    bit            m_ovf = 0;
    bit            m_vld = 0;
    bit            m_done = 0;
    logic [PW-1:0] m_hold = '0;

    task automatic model_step(input bit vld, input logic [7:0] dat, input bit en, input bit fs);
        logic [15:0] d1, d2;
        logic [10:0] px, py;
        m_vld  = 0;
        m_done = 0;
        if (!rst_n) begin
            grp.delete();
            pix_count = 0; running = 0; frame_over = 0; m_ovf = 0; m_hold = '0;
        end else if (fs) begin
            grp.delete();
            pix_count = 0; running = 1; frame_over = 0; m_ovf = 0;
        end else if (running) begin
            if (!en) grp.delete();
            else if (vld) begin
                grp.push_back(dat);
                if (grp.size() == 6) begin
                    d2 = {grp[0][7:3], grp[1][7:2], grp[2][7:3]};
                    d1 = {grp[3][7:3], grp[4][7:2], grp[5][7:3]};
                    px = 11'(pix_count % W);
                    py = 11'(pix_count / W);
                    m_hold = {d1, d2, px, py};
                    exp_q.push_back(m_hold);
                    m_vld = 1;
                    grp.delete();
                    pix_count++;
                    if (pix_count == W * H) begin
                        m_done = 1; running = 0; frame_over = 1;
                    end
                end
            end
        end else if (frame_over && vld) begin
            m_ovf = 1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input bit vld, input logic [7:0] dat, input bit en, input bit fs);
        logic [PW-1:0] got_pix, exp_pix;
        bus.byte_vld    = vld;
        bus.byte_dat    = dat;
        bus.stream_en   = en;
        bus.frame_start = fs;
        model_step(vld, dat, en, fs);
        @(posedge clk);
        #1;
        got_pix = {bus.pix_dat1, bus.pix_dat2, bus.pixX, bus.pixY};
        check_eq("pix_vld", 64'(bus.pix_vld), 64'(m_vld));
        check_eq("frame_done", 64'(bus.frame_done), 64'(m_done));
        check_eq("busy", 64'(bus.busy), 64'(running));
        check_eq("ovf", 64'(bus.ovf), 64'(m_ovf));
        check_eq("pix_hold", 64'(got_pix), 64'(m_hold));
        if (bus.pix_vld) begin
            if (exp_q.size() == 0) check_eq("unexpected_pix", 64'(1), 64'(0));
            else begin
                exp_pix = exp_q.pop_front();
                check_eq("pix_word", 64'(got_pix), 64'(exp_pix));
            end
        end
    endtask

    task automatic send_bytes(input logic [7:0] b0, b1, b2, b3, b4, b5);
        drive_cycle(1, b0, 1, 0); drive_cycle(1, b1, 1, 0); drive_cycle(1, b2, 1, 0);
        drive_cycle(1, b3, 1, 0); drive_cycle(1, b4, 1, 0); drive_cycle(1, b5, 1, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 8'h00, 1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.byte_vld = 0; bus.byte_dat = 0; bus.stream_en = 0; bus.frame_start = 0;

        // Reset state
        rst_n = 0;
        drive_cycle(0, 8'h00, 0, 0);
        drive_cycle(1, 8'h12, 1, 0);
        rst_n = 1;
        idle_cycles(1);

        // Basic pack
        drive_cycle(0, 8'h00, 1, 1);
        send_bytes(8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00);
        check_eq("basic_vld", 64'(bus.pix_vld), 64'(1));
        check_eq("basic_dat2", 64'(bus.pix_dat2), 64'h F81F);
        check_eq("basic_dat1", 64'(bus.pix_dat1), 64'h07E0);
        check_eq("basic_xy", 64'({bus.pixX, bus.pixY}), 64'(0));

        // Rest of the frame, back-to-back random bytes
        for (int i = 0; i < 42; i++) drive_cycle(1, 8'($urandom_range(0, 255)), 1, 0);
        check_eq("frame_done_last", 64'(bus.frame_done), 64'(1));
        check_eq("last_xy", 64'({bus.pixX, bus.pixY}), 64'({11'd3, 11'd1}));
        idle_cycles(2);

        // Overrun
        drive_cycle(1, 8'h5A, 1, 0);
        idle_cycles(1);
        check_eq("ovf_set", 64'(bus.ovf), 64'(1));
        drive_cycle(0, 8'h00, 1, 1);
        check_eq("ovf_clear", 64'(bus.ovf), 64'(0));

        // Gate drop
        for (int i = 0; i < 4; i++) drive_cycle(1, 8'($urandom_range(0, 255)), 1, 0);
        drive_cycle(0, 8'h00, 0, 0);
        send_bytes(8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55);
        check_eq("gate_dat2", 64'(bus.pix_dat2), 64'h AAB5);
        check_eq("gate_dat1", 64'(bus.pix_dat1), 64'h554A);
        check_eq("gate_x", 64'(bus.pixX), 64'(0));
        idle_cycles(1);

        // stream_en falling with the sixth byte
        for (int i = 0; i < 5; i++) drive_cycle(1, 8'($urandom_range(0, 255)), 1, 0);
        drive_cycle(1, 8'hC3, 0, 0);
        // frame_start on the sixth byte
        for (int i = 0; i < 5; i++) drive_cycle(1, 8'($urandom_range(0, 255)), 1, 0);
        drive_cycle(1, 8'h3C, 1, 1);
        send_bytes(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
        check_eq("collide_xy", 64'({bus.pixX, bus.pixY}), 64'(0));

        // byte_vld in IDLE
        rst_n = 0;
        drive_cycle(0, 8'h00, 1, 0);
        rst_n = 1;
        for (int i = 0; i < 8; i++) drive_cycle(1, 8'($urandom_range(0, 255)), 1, 0);
        check_eq("idle_ovf", 64'(bus.ovf), 64'(0));

        // Mid-frame reset during pixel 3
        drive_cycle(0, 8'h00, 1, 1);
        for (int i = 0; i < 15; i++) drive_cycle(1, 8'($urandom_range(0, 255)), 1, 0);
        rst_n = 0;
        drive_cycle(1, 8'h77, 1, 0);
        rst_n = 1;
        check_eq("rst_dbg_state", 64'(dbg_state), 64'(0));
        for (int i = 0; i < 12; i++) drive_cycle(1, 8'($urandom_range(0, 255)), 1, 0);

        // Randomized phase
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            drive_cycle(bit'($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)),
                        bit'($urandom_range(0, 19) != 0), bit'($urandom_range(0, 99) == 0));
        end
        rst_n = 1;
        idle_cycles(2);

        check_eq("exp_q_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
